comparator_seq: RTL and testbench

- Multi-cycle, parametrised magnitude/equality comparator with a valid/ready handshake on both sides.
- Compares two N-bit operands MSB-first in CHUNK-bit slices, one slice per clock, and terminates early on the first differing slice.
- A per-transaction is_signed flag selects signed or unsigned less-than.
- Sits in the datapath where a full-width single-cycle comparator would limit timing, e.g. feeding branch/SLT logic in the processor.

---
 rtl/comparator_pkg.sv | 21 ++
 rtl/comparator_chunk.sv | 24 ++
 rtl/comparator_seq.sv | 112 +++++++++++
 tb/tb_comparator_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and sizing helpers for the sequential slice-by-slice comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    function automatic int chunk_count(input int n, input int chunk);
        return n / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n, input int chunk);
        int cnt;
        cnt = n / chunk;
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational compare of one W-bit slice; invert_msb turns a two's-complement
// top slice into offset binary so a plain unsigned compare orders it correctly.
module comparator_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         invert_msb,
    output logic         eq,
    output logic         lt
);

    logic [W-1:0] msb_mask;
    logic [W-1:0] x_adj;
    logic [W-1:0] y_adj;

    assign msb_mask = W'(1) << (W - 1);
    assign x_adj    = invert_msb ? (x ^ msb_mask) : x;
    assign y_adj    = invert_msb ? (y ^ msb_mask) : y;

    assign eq = (x == y);
    assign lt = (x_adj < y_adj);

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude/equality comparator: walks the operands MSB-first one
// CHUNK-bit slice per clock and stops at the first slice that differs.
module comparator_seq
    import comparator_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         equals,
    output logic         less_than,
    output logic         busy
);

    localparam int NUM_CHUNKS = chunk_count(N, CHUNK);
    localparam int IDX_W      = idx_width(N, CHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_params
            $error("comparator_seq: N (%0d) must be a multiple of CHUNK (%0d), 1 <= CHUNK <= N", N, CHUNK);
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic               signed_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic               slice_eq;
    logic               slice_lt;
    logic               top_slice;

    assign slice_a   = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_b   = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign top_slice = (idx_q == LAST_IDX);

    // Only the slice holding the sign bit needs the offset-binary treatment.
    comparator_chunk #(
        .W(CHUNK)
    ) u_chunk (
        .x          (slice_a),
        .y          (slice_b),
        .invert_msb (signed_q && top_slice),
        .eq         (slice_eq),
        .lt         (slice_lt)
    );

    assign i_ready = (state == S_IDLE) && !rst;
    assign o_valid = (state == S_DONE);
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (i_valid) state_next = S_COMPARE;
            S_COMPARE: if (!slice_eq || idx_q == '0) state_next = S_DONE;
            S_DONE:    if (o_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Result flags are only written on the deciding cycle, so they hold
    // their last value outside S_DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            idx_q     <= '0;
            equals    <= 1'b0;
            less_than <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= is_signed;
                        idx_q    <= LAST_IDX;
                    end
                end
                S_COMPARE: begin
                    if (!slice_eq) begin
                        equals    <= 1'b0;
                        less_than <= slice_lt;
                    end else if (idx_q == '0) begin
                        equals    <= 1'b1;
                        less_than <= 1'b0;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Randomised self-checking bench for comparator_seq against a full-width
// arithmetic reference model.
module tb_comparator_seq;

    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int NC    = N / CHUNK;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         is_signed;
    logic         o_valid;
    logic         o_ready;
    logic         equals;
    logic         less_than;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    comparator_seq #(
        .N     (N),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .equals    (equals),
        .less_than (less_than),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width arithmetic compare; k is the number of MSB-first
    // slices inspected up to and including the first difference.
    function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                  input logic ms, output logic eq, output logic lt,
                                  output int k);
        logic found;
        eq    = (ma == mb);
        lt    = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
        k     = NC;
        found = 1'b0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (!found && ma[i*CHUNK +: CHUNK] != mb[i*CHUNK +: CHUNK]) begin
                k     = NC - i;
                found = 1'b1;
            end
        end
    endfunction

    // Entered and left at a negedge; returns once o_valid is seen or the bound expires.
    task automatic start_txn(input logic [N-1:0] ta, input logic [N-1:0] tb,
                             input logic ts, output int lat, output int acc_cyc,
                             output logic ok);
        int wait_cnt;
        ok        = 1'b1;
        a         = ta;
        b         = tb;
        is_signed = ts;
        wait_cnt  = 0;
        while (!i_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!i_ready) begin
            checks++;
            errors++;
            ok = 1'b0;
            $display("[TB] FAIL accept_timeout: i_ready=%b required 1", i_ready);
            return;
        end
        i_valid = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        i_valid = 1'b0;
        lat     = 0;
        while (!o_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!o_valid) begin
            checks++;
            errors++;
            ok = 1'b0;
            $display("[TB] FAIL result_timeout: o_valid=%b required 1 after %0d cycles", o_valid, lat);
        end
    endtask

    task automatic release_result();
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_valid, equals, less_than, busy, i_ready} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: o_valid/eq/lt/busy/i_ready=%b required 00000",
                     {o_valid, equals, less_than, busy, i_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: i_ready=%b required 1", i_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [N-1:0] va [7];
        logic [N-1:0] vb [7];
        logic         vs [7];
        logic eq_e, lt_e, ok;
        int   k_e, lat, acc;
        va = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00009581, 32'h12345678, 32'h12345679, 32'h0};
        vb = '{32'h0, 32'h1,        32'h1,        32'h000003E8, 32'h12345679, 32'h12345678, 32'h0};
        vs = '{1'b1,  1'b1,         1'b0,         1'b0,         1'b1,         1'b1,         1'b0};
        for (int i = 0; i < 7; i++) begin
            model(va[i], vb[i], vs[i], eq_e, lt_e, k_e);
            start_txn(va[i], vb[i], vs[i], lat, acc, ok);
            if (ok) begin
                checks++;
                if (equals !== eq_e || less_than !== lt_e || lat != k_e) begin
                    errors++;
                    $display("[TB] FAIL directed_%0d: eq=%b lt=%b k=%0d required eq=%b lt=%b k=%0d",
                             i, equals, less_than, lat, eq_e, lt_e, k_e);
                end
            end
            release_result();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ra, rb;
        logic rs, eq_e, lt_e, ok;
        int   k_e, lat, acc, sel;
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = ra;
            sel = $urandom_range(0, NC);
            // Perturb one slice (or none) so early and late exits are both hit.
            if (sel < NC) rb[sel*CHUNK +: CHUNK] = CHUNK'($urandom);
            if ($urandom_range(0, 3) == 0) rb = $urandom;
            rs = 1'($urandom);
            model(ra, rb, rs, eq_e, lt_e, k_e);
            start_txn(ra, rb, rs, lat, acc, ok);
            if (ok) begin
                checks++;
                if (equals !== eq_e || less_than !== lt_e || lat != k_e) begin
                    errors++;
                    $display("[TB] FAIL random_%0d: a=%h b=%h s=%b eq=%b lt=%b k=%0d required eq=%b lt=%b k=%0d",
                             i, ra, rb, rs, equals, less_than, lat, eq_e, lt_e, k_e);
                end
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic eq_e, lt_e, ok, bad;
        int   k_e, lat, acc;
        model(32'h80000000, 32'h00000001, 1'b1, eq_e, lt_e, k_e);
        start_txn(32'h80000000, 32'h00000001, 1'b1, lat, acc, ok);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            if (o_valid !== 1'b1 || equals !== eq_e || less_than !== lt_e || i_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (!ok || bad) begin
            errors++;
            $display("[TB] FAIL backpressure_hold: o_valid=%b eq=%b lt=%b i_ready=%b required 1 %b %b 0",
                     o_valid, equals, less_than, i_ready, eq_e, lt_e);
        end
        release_result();
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_release: i_ready=%b o_valid=%b required 1 0", i_ready, o_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic eq_e, lt_e, seen;
        int   k_e, lat, acc;
        logic ok;
        a         = 32'd5;
        b         = 32'd5;
        is_signed = 1'b1;
        i_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_valid, equals, less_than} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: o_valid/eq/lt=%b required 000", {o_valid, equals, less_than});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_ready: i_ready=%b required 1", i_ready);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL reset_mid_no_result: o_valid seen=%b required 0", seen);
        end
        model(-32'sd2, 32'sd3, 1'b1, eq_e, lt_e, k_e);
        start_txn(-32'sd2, 32'sd3, 1'b1, lat, acc, ok);
        if (ok) begin
            checks++;
            if (less_than !== lt_e || equals !== eq_e || lat != k_e) begin
                errors++;
                $display("[TB] FAIL reset_mid_follow: eq=%b lt=%b k=%0d required eq=%b lt=%b k=%0d",
                         equals, less_than, lat, eq_e, lt_e, k_e);
            end
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ra, rb;
        logic rs, eq_e, lt_e, ok;
        int   k_e, lat, acc, prev_acc, prev_k;
        prev_acc = -1;
        prev_k   = 0;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = ra;
            rb[$urandom_range(0, NC - 1)*CHUNK +: CHUNK] = CHUNK'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, eq_e, lt_e, k_e);
            start_txn(ra, rb, rs, lat, acc, ok);
            if (ok && prev_acc >= 0) begin
                checks++;
                if (acc - prev_acc != prev_k + 2) begin
                    errors++;
                    $display("[TB] FAIL back_to_back_%0d: spacing=%0d required %0d",
                             i, acc - prev_acc, prev_k + 2);
                end
            end
            prev_acc = acc;
            prev_k   = k_e;
            release_result();
        end
    endtask

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        o_ready   = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
